// File: rtl/sa_or_reduce_acc_pkg.sv
// Shared constants, counter helpers and the frame summary record for the OR-reduce accumulator.
package sa_or_reduce_pkg;

  localparam int W_DEF     = 8;
  localparam int CNT_W_DEF = 8;

  function automatic logic [31:0] cnt_max(input int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

  localparam logic [31:0] CNT_MAX = cnt_max(CNT_W_DEF);

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v >= max) ? max : v + 32'd1;
  endfunction

  // Summary record at the default widths; the top builds its own at its parameter widths.
  typedef struct packed {
    logic [W_DEF-1:0]     pd;
    logic [CNT_W_DEF-1:0] cnt;
  } frame_sum_t;

endpackage

// File: rtl/sa_or_reduce_acc_if.sv
// Beat input and frame-summary output handshakes of the OR-reduce accumulator.
interface sa_or_reduce_acc_if #(
  parameter int NCH   = 4,
  parameter int W     = 8,
  parameter int CNT_W = 8
);
  logic               in_pvld;
  logic               in_prdy;
  logic [NCH*W-1:0]   in_pd;
  logic               in_last;
  logic               out_pvld;
  logic               out_prdy;
  logic [W-1:0]       out_pd;
  logic [CNT_W-1:0]   out_cnt;
  logic               out_any;

  modport master (
    output in_pvld, in_pd, in_last, out_prdy,
    input  in_prdy, out_pvld, out_pd, out_cnt, out_any
  );

  modport slave (
    input  in_pvld, in_pd, in_last, out_prdy,
    output in_prdy, out_pvld, out_pd, out_cnt, out_any
  );
endinterface

// File: rtl/sa_or_reduce_acc_or_tree.sv
// Combinational NCH x W -> W OR reducer built as a balanced tree of 2-input ORs.
module sa_or_tree #(
  parameter int NCH = 4,
  parameter int W   = 8
) (
  input  logic [NCH*W-1:0] in_pd_i,
  output logic [W-1:0]     red_o
);
  logic [W-1:0] lvl [NCH];

  // Pairwise fold with doubling stride keeps the depth at ceil(log2(NCH)).
  always_comb begin
    for (int i = 0; i < NCH; i++) lvl[i] = in_pd_i[i*W +: W];
    for (int step = 1; step < NCH; step = step * 2) begin
      for (int i = 0; i + step < NCH; i = i + 2 * step) lvl[i] = lvl[i] | lvl[i+step];
    end
    red_o = lvl[0];
  end
endmodule

// File: rtl/sa_or_reduce_acc.sv
// Frame-level OR accumulator with saturating beat count and a one-entry summary slot.
// Define SA_OR_REDUCE_PIPE_EN to register the channel reduction ahead of the accumulator.
module sa_or_reduce_acc
  import sa_or_reduce_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  sa_or_reduce_acc_if.slave bus
);
  localparam logic [31:0] CMAX = cnt_max(CNT_W);

  typedef struct packed {
    logic [W-1:0]     pd;
    logic [CNT_W-1:0] cnt;
  } sum_t;

  logic [W-1:0]     red;
  logic [W-1:0]     acc_q, acc_d, merged;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  sum_t             sum_q, sum_d;
  logic             pvld_q, pvld_d;
  logic             out_adv, in_fire, acc_en, acc_last;
  logic [W-1:0]     acc_red;

  sa_or_tree #(.NCH(NCH), .W(W)) u_tree (
    .in_pd_i (bus.in_pd),
    .red_o   (red)
  );

  assign out_adv = ~pvld_q | bus.out_prdy;
  assign in_fire = bus.in_pvld & bus.in_prdy;

`ifdef SA_OR_REDUCE_PIPE_EN
  logic         stg_vld_q, stg_last_q;
  logic [W-1:0] stg_red_q;

  assign bus.in_prdy = ~stg_vld_q | out_adv;
  assign acc_en      = stg_vld_q & out_adv;
  assign acc_red     = stg_red_q;
  assign acc_last    = stg_last_q;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      stg_vld_q  <= 1'b0;
      stg_red_q  <= '0;
      stg_last_q <= 1'b0;
    end else if (in_fire) begin
      stg_vld_q  <= 1'b1;
      stg_red_q  <= red;
      stg_last_q <= bus.in_last;
    end else if (out_adv) begin
      stg_vld_q  <= 1'b0;
    end
  end
`else
  assign bus.in_prdy = out_adv;
  assign acc_en      = in_fire;
  assign acc_red     = red;
  assign acc_last    = bus.in_last;
`endif

  // A closing beat may land in the same cycle the old summary drains, so no bubble.
  always_comb begin
    merged  = acc_q | acc_red;
    cnt_inc = CNT_W'(sat_inc(32'(cnt_q), CMAX));
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    pvld_d  = pvld_q & ~bus.out_prdy;
    if (acc_en) begin
      if (acc_last) begin
        sum_d.pd  = merged;
        sum_d.cnt = cnt_inc;
        pvld_d    = 1'b1;
        acc_d     = '0;
        cnt_d     = '0;
      end else begin
        acc_d = merged;
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      sum_q  <= '0;
      pvld_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      sum_q  <= sum_d;
      pvld_q <= pvld_d;
    end
  end

  assign bus.out_pvld = pvld_q;
  assign bus.out_pd   = sum_q.pd;
  assign bus.out_cnt  = sum_q.cnt;
  assign bus.out_any  = |sum_q.pd;
endmodule

// File: tb/tb_sa_or_reduce_acc.sv
// Bench for sa_or_reduce_acc (NCH=4, W=8, CNT_W=3): directed scenarios plus randomized frames
// checked against a frame-level OR/count model.
module tb_sa_or_reduce_acc;
  localparam int NCH   = 4;
  localparam int W     = 8;
  localparam int CNT_W = 3;
  localparam int CMAX  = 7;
`ifdef SA_OR_REDUCE_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  sa_or_reduce_acc_if #(.NCH(NCH), .W(W), .CNT_W(CNT_W)) bus ();

  sa_or_reduce_acc #(.NCH(NCH), .W(W), .CNT_W(CNT_W)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .bus             (bus)
  );

  typedef struct {
    logic [NCH*W-1:0] pd;
    logic             last;
  } beat_t;

  typedef struct {
    logic [W-1:0] pd;
    int           cnt;
    bit           any;
  } sum_t;

  beat_t stim_q[$];
  sum_t  exp_q[$];
  sum_t  obs_q[$];
  bit    rand_rdy = 0;
  int    n_chk = 0;
  int    n_pass = 0;

  always @(negedge clk)
    if (rstn && bus.out_pvld && bus.out_prdy)
      obs_q.push_back('{pd: bus.out_pd, cnt: int'(bus.out_cnt), any: bus.out_any});

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference: a frame's summary is the OR of every channel of every beat, count = min(n, CMAX).
  task automatic add_frame(input int n, input bit zero);
    logic [W-1:0]     acc;
    logic [NCH*W-1:0] pd;
    acc = '0;
    for (int i = 0; i < n; i++) begin
      pd = '0;
      if (!zero)
        for (int c = 0; c < NCH; c++)
          if ($urandom_range(0, 3) == 0) pd[c*W +: W] = W'(1) << $urandom_range(0, W-1);
      for (int c = 0; c < NCH; c++) acc = acc | pd[c*W +: W];
      stim_q.push_back('{pd: pd, last: (i == n-1)});
    end
    exp_q.push_back('{pd: acc, cnt: (n > CMAX) ? CMAX : n, any: (acc != '0)});
  endtask

  task automatic run_stim(input bit gaps);
    int guard;
    bit acc;
    guard = 0;
    while (stim_q.size() > 0 && guard < 5000) begin
      if (gaps && $urandom_range(0, 3) == 0) bus.in_pvld = 1'b0;
      else begin
        bus.in_pvld = 1'b1;
        bus.in_pd   = stim_q[0].pd;
        bus.in_last = stim_q[0].last;
      end
      if (rand_rdy) bus.out_prdy = ($urandom_range(0, 99) < 60);
      @(negedge clk);
      acc = bus.in_pvld && bus.in_prdy;
      wait_cycle();
      if (acc) void'(stim_q.pop_front());
      guard++;
    end
    bus.in_pvld  = 1'b0;
    bus.in_last  = 1'b0;
    bus.out_prdy = 1'b1;
    repeat (LAT + 3) wait_cycle();
    n_chk++;
    if (guard >= 5000) $display("FAIL stim_timeout beats_left=%0d want 0", stim_q.size());
    else n_pass++;
    stim_q.delete();
  endtask

  task automatic test_reset();
    bus.out_prdy = 1'b0;
    #2 rstn = 1'b0;
    wait_cycle();
    wait_cycle();
    n_chk++; if (bus.out_pvld !== 1'b0) $display("FAIL reset_out_pvld got %b want 0", bus.out_pvld); else n_pass++;
    n_chk++; if (bus.out_pd !== 8'h00) $display("FAIL reset_out_pd got %h want 00", bus.out_pd); else n_pass++;
    n_chk++; if (bus.out_cnt !== 3'd0) $display("FAIL reset_out_cnt got %0d want 0", bus.out_cnt); else n_pass++;
    n_chk++; if (bus.out_any !== 1'b0) $display("FAIL reset_out_any got %b want 0", bus.out_any); else n_pass++;
    n_chk++; if (bus.in_prdy !== 1'b1) $display("FAIL reset_in_prdy got %b want 1", bus.in_prdy); else n_pass++;
    rstn = 1'b1;
    wait_cycle();
  endtask

  task automatic test_single_beat();
    int lat;
    bus.out_prdy = 1'b1;
    bus.in_pvld  = 1'b1;
    bus.in_pd    = 32'h0100_8000;
    bus.in_last  = 1'b1;
    wait_cycle();
    bus.in_pvld = 1'b0;
    lat = 1;
    while (bus.out_pvld !== 1'b1 && lat < 8) begin wait_cycle(); lat++; end
    n_chk++; if (lat != LAT) $display("FAIL single_latency got %0d want %0d", lat, LAT); else n_pass++;
    n_chk++; if (bus.out_pd !== 8'h81) $display("FAIL single_pd got %h want 81", bus.out_pd); else n_pass++;
    n_chk++; if (bus.out_cnt !== 3'd1) $display("FAIL single_cnt got %0d want 1", bus.out_cnt); else n_pass++;
    n_chk++; if (bus.out_any !== 1'b1) $display("FAIL single_any got %b want 1", bus.out_any); else n_pass++;
    repeat (3) wait_cycle();
  endtask

  task automatic test_multi_beat();
    int lat;
    obs_q.delete();
    bus.out_prdy = 1'b1;
    for (int b = 0; b < 3; b++) begin
      bus.in_pvld = 1'b1;
      bus.in_pd   = 32'(1) << b;
      bus.in_last = (b == 2);
      wait_cycle();
      if (b < 2) begin
        n_chk++;
        if (bus.out_pvld !== 1'b0) $display("FAIL multi_early_pvld beat=%0d got %b want 0", b, bus.out_pvld);
        else n_pass++;
      end
    end
    bus.in_pvld = 1'b0;
    bus.in_last = 1'b0;
    lat = 1;
    while (bus.out_pvld !== 1'b1 && lat < 8) begin wait_cycle(); lat++; end
    n_chk++; if (lat != LAT) $display("FAIL multi_latency got %0d want %0d", lat, LAT); else n_pass++;
    n_chk++; if (bus.out_pd !== 8'h07) $display("FAIL multi_pd got %h want 07", bus.out_pd); else n_pass++;
    n_chk++; if (bus.out_cnt !== 3'd3) $display("FAIL multi_cnt got %0d want 3", bus.out_cnt); else n_pass++;
    repeat (3) wait_cycle();
    n_chk++; if (obs_q.size() != 1) $display("FAIL multi_nsum got %0d want 1", obs_q.size()); else n_pass++;
  endtask

  task automatic test_backpressure();
    int  lat;
    bit  pend;
    obs_q.delete();
    bus.out_prdy = 1'b0;
    bus.in_pvld  = 1'b1;
    bus.in_pd    = 32'h0000_0003;
    bus.in_last  = 1'b1;
    wait_cycle();
    bus.in_pvld = 1'b0;
    lat = 1;
    while (bus.out_pvld !== 1'b1 && lat < 8) begin wait_cycle(); lat++; end
    n_chk++; if (lat != LAT) $display("FAIL bp_latency got %0d want %0d", lat, LAT); else n_pass++;
    // Offer the next frame's closing beat while the slot is held.
    bus.in_pvld = 1'b1;
    bus.in_pd   = 32'h0000_0C00;
    bus.in_last = 1'b1;
    pend = 1;
    @(negedge clk);
    if (bus.in_prdy) pend = 0;
    wait_cycle();
    if (!pend) bus.in_pvld = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_chk++; if (bus.in_prdy !== 1'b0) $display("FAIL bp_in_prdy cyc=%0d got %b want 0", i, bus.in_prdy); else n_pass++;
      n_chk++; if (bus.out_pvld !== 1'b1) $display("FAIL bp_hold_pvld cyc=%0d got %b want 1", i, bus.out_pvld); else n_pass++;
      n_chk++; if (bus.out_pd !== 8'h03) $display("FAIL bp_hold_pd cyc=%0d got %h want 03", i, bus.out_pd); else n_pass++;
      n_chk++; if (bus.out_cnt !== 3'd1) $display("FAIL bp_hold_cnt cyc=%0d got %0d want 1", i, bus.out_cnt); else n_pass++;
      wait_cycle();
    end
    bus.out_prdy = 1'b1;
    @(negedge clk);
    if (pend) begin
      n_chk++; if (bus.in_prdy !== 1'b1) $display("FAIL bp_release_prdy got %b want 1", bus.in_prdy); else n_pass++;
    end
    wait_cycle();
    bus.in_pvld = 1'b0;
    bus.in_last = 1'b0;
    n_chk++; if (bus.out_pvld !== 1'b1) $display("FAIL b2b_pvld got %b want 1", bus.out_pvld); else n_pass++;
    n_chk++; if (bus.out_pd !== 8'h0C) $display("FAIL b2b_pd got %h want 0c", bus.out_pd); else n_pass++;
    n_chk++; if (bus.out_cnt !== 3'd1) $display("FAIL b2b_cnt got %0d want 1", bus.out_cnt); else n_pass++;
    wait_cycle();
    n_chk++; if (bus.out_pvld !== 1'b0) $display("FAIL drain_pvld got %b want 0", bus.out_pvld); else n_pass++;
    n_chk++; if (obs_q.size() != 2) $display("FAIL bp_nsum got %0d want 2", obs_q.size()); else n_pass++;
  endtask

  task automatic test_zero_frame();
    obs_q.delete();
    bus.out_prdy = 1'b1;
    for (int i = 0; i < 5; i++) stim_q.push_back('{pd: '0, last: (i == 4)});
    run_stim(0);
    n_chk++;
    if (obs_q.size() != 1) $display("FAIL zero_nsum got %0d want 1", obs_q.size());
    else begin
      n_pass++;
      n_chk++; if (obs_q[0].pd !== 8'h00) $display("FAIL zero_pd got %h want 00", obs_q[0].pd); else n_pass++;
      n_chk++; if (obs_q[0].any !== 1'b0) $display("FAIL zero_any got %b want 0", obs_q[0].any); else n_pass++;
      n_chk++; if (obs_q[0].cnt != 5) $display("FAIL zero_cnt got %0d want 5", obs_q[0].cnt); else n_pass++;
    end
  endtask

  task automatic test_saturation();
    obs_q.delete();
    exp_q.delete();
    bus.out_prdy = 1'b1;
    add_frame(12, 0);
    run_stim(0);
    n_chk++;
    if (obs_q.size() != 1) $display("FAIL sat_nsum got %0d want 1", obs_q.size());
    else begin
      n_pass++;
      n_chk++; if (obs_q[0].cnt != CMAX) $display("FAIL sat_cnt got %0d want %0d", obs_q[0].cnt, CMAX); else n_pass++;
      n_chk++; if (obs_q[0].pd !== exp_q[0].pd) $display("FAIL sat_pd got %h want %h", obs_q[0].pd, exp_q[0].pd); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    obs_q.delete();
    bus.out_prdy = 1'b1;
    for (int i = 0; i < 2; i++) stim_q.push_back('{pd: 32'h0000_0010, last: 1'b0});
    run_stim(0);
    rstn = 1'b0;
    wait_cycle();
    rstn = 1'b1;
    wait_cycle();
    stim_q.push_back('{pd: 32'h0000_0001, last: 1'b1});
    run_stim(0);
    n_chk++;
    if (obs_q.size() != 1) $display("FAIL rmid_nsum got %0d want 1", obs_q.size());
    else begin
      n_pass++;
      n_chk++; if (obs_q[0].pd !== 8'h01) $display("FAIL rmid_pd got %h want 01", obs_q[0].pd); else n_pass++;
      n_chk++; if (obs_q[0].cnt != 1) $display("FAIL rmid_cnt got %0d want 1", obs_q[0].cnt); else n_pass++;
    end
    // Reset while a summary is held drops it.
    bus.out_prdy = 1'b0;
    bus.in_pvld  = 1'b1;
    bus.in_pd    = 32'h0000_4000;
    bus.in_last  = 1'b1;
    wait_cycle();
    bus.in_pvld = 1'b0;
    lat = 1;
    while (bus.out_pvld !== 1'b1 && lat < 8) begin wait_cycle(); lat++; end
    n_chk++; if (bus.out_pd !== 8'h40) $display("FAIL rfull_pd got %h want 40", bus.out_pd); else n_pass++;
    rstn = 1'b0;
    #1;
    n_chk++; if (bus.out_pvld !== 1'b0) $display("FAIL rfull_pvld got %b want 0", bus.out_pvld); else n_pass++;
    n_chk++; if (bus.out_pd !== 8'h00) $display("FAIL rfull_pd_clr got %h want 00", bus.out_pd); else n_pass++;
    wait_cycle();
    rstn = 1'b1;
    bus.in_last  = 1'b0;
    bus.out_prdy = 1'b1;
    wait_cycle();
  endtask

  task automatic test_random();
    int n;
    obs_q.delete();
    exp_q.delete();
    for (int f = 0; f < 40; f++) add_frame($urandom_range(1, 12), ($urandom_range(0, 9) == 0));
    rand_rdy = 1;
    run_stim(1);
    rand_rdy = 0;
    n_chk++;
    if (obs_q.size() != exp_q.size()) $display("FAIL rand_nsum got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_chk++;
      if (obs_q[i].pd !== exp_q[i].pd || obs_q[i].cnt != exp_q[i].cnt || obs_q[i].any !== exp_q[i].any)
        $display("FAIL rand_frame idx=%0d got pd=%h cnt=%0d any=%b want pd=%h cnt=%0d any=%b",
                 i, obs_q[i].pd, obs_q[i].cnt, obs_q[i].any, exp_q[i].pd, exp_q[i].cnt, exp_q[i].any);
      else n_pass++;
    end
  endtask

  initial begin
    bus.in_pvld  = 1'b0;
    bus.in_pd    = '0;
    bus.in_last  = 1'b0;
    bus.out_prdy = 1'b1;
    test_reset();
    test_single_beat();
    test_multi_beat();
    test_backpressure();
    test_zero_frame();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
